pwm_spi_regs: RTL and testbench

- SPI-slave configuration front-end sitting directly upstream of the PWM generator core in the tt_um_mme_pwm_generator top.
- Receives 16-bit SPI mode-0 frames on ui_in/uio pins, holds CTRL/DUTY/PERIOD registers, and drives the core's enable, invert, duty and period inputs.
- DUTY/PERIOD are double-buffered. New values reach the core only at a PWM period boundary (period_end_i), or immediately while the core is disabled, so the core never sees a glitched cycle.

---
 rtl/pwm_spi_regs_if.sv | 22 ++
 rtl/pwm_spi_regs.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pwm_spi_regs.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_spi_regs_if.sv
// SPI pin bundle between an SPI master and the pwm_spi_regs configuration slave.
// Signal names keep the slave-side pin names so the top-level wiring reads the same.
interface pwm_spi_regs_if;
    logic sclk_i;
    logic cs_n_i;
    logic mosi_i;
    logic miso_o;

    modport master (
        output sclk_i,
        output cs_n_i,
        output mosi_i,
        input  miso_o
    );

    modport slave (
        input  sclk_i,
        input  cs_n_i,
        input  mosi_i,
        output miso_o
    );
endinterface

// File: rtl/pwm_spi_regs.sv
// SPI-slave configuration registers feeding the PWM generator core.
// Receives 16-bit mode-0 frames (W, addr[6:0], data[7:0], MSB first), holds
// CTRL/DUTY/PERIOD and hands DUTY/PERIOD to the core through a shadow stage that
// only reloads on a PWM period boundary or while the core is disabled.
// Optional build macro: PWM_SPI_READBACK_EN enables register readback on miso.
// Without it miso is tied low and read frames have no effect.
module pwm_spi_regs #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [7:0]  RESET_PERIOD = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_spi_regs_if.slave      spi,
    input  logic               period_end_i,
    output logic               pwm_en_o,
    output logic               pwm_inv_o,
    output logic [7:0]         duty_o,
    output logic [7:0]         period_o,
    output logic               update_o
);

    // A single-flop synchroniser is not safe, so anything below 2 is raised to 2.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [6:0] ADDR_CTRL   = 7'h00;
    localparam logic [6:0] ADDR_DUTY   = 7'h01;
    localparam logic [6:0] ADDR_PERIOD = 7'h02;
    localparam logic [6:0] ADDR_STATUS = 7'h03;

    // Synchroniser chains and edge-detect history
    logic [SYNC_N-1:0] sclkSync_q;
    logic [SYNC_N-1:0] csSync_q;
    logic [SYNC_N-1:0] mosiSync_q;
    logic              sclkDly_q;
    logic              csDly_q;

    logic sclkS;
    logic csS;
    logic mosiS;
    logic sclkRise;
    logic csFall;

    // Frame receiver
    logic [1:0]  state_q,  state_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [15:0] shift_q,  shift_d;

    // Register file and shadow stage
    logic        ctrlEn_q,      ctrlEn_d;
    logic        ctrlInv_q,     ctrlInv_d;
    logic [7:0]  dutyStage_q,   dutyStage_d;
    logic [7:0]  periodStage_q, periodStage_d;
    logic [7:0]  duty_q,        duty_d;
    logic [7:0]  period_q,      period_d;
    logic        pending_q,     pending_d;
    logic        update_q,      update_d;

    logic        commitWr;
    logic [6:0]  wrAddr;
    logic [7:0]  wrData;
    logic        transfer;

    // Bring the asynchronous SPI pins into the clk domain and keep one-cycle-old copies for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkDly_q  <= 1'b0;
            csDly_q    <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_N-2:0], spi.sclk_i};
            csSync_q   <= {csSync_q[SYNC_N-2:0],   spi.cs_n_i};
            mosiSync_q <= {mosiSync_q[SYNC_N-2:0], spi.mosi_i};
            sclkDly_q  <= sclkSync_q[SYNC_N-1];
            csDly_q    <= csSync_q[SYNC_N-1];
        end
    end

    assign sclkS    = sclkSync_q[SYNC_N-1];
    assign csS      = csSync_q[SYNC_N-1];
    assign mosiS    = mosiSync_q[SYNC_N-1];
    assign sclkRise = sclkS & ~sclkDly_q;
    assign csFall   = csDly_q & ~csS;

    // Frame FSM: collect 16 bits, commit once, then ignore sclk until chip select is released
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (csFall) begin
                    state_d  = ST_SHIFT;
                    bitCnt_d = 5'd0;
                    shift_d  = 16'h0000;
                end
            end
            ST_SHIFT: begin
                if (csS) begin
                    state_d = ST_IDLE;
                end else if (sclkRise) begin
                    shift_d  = {shift_q[14:0], mosiS};
                    bitCnt_d = bitCnt_q + 5'd1;
                    if (bitCnt_q == 5'd15) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = csS ? ST_IDLE : ST_DONE;
            end
            default: begin
                if (csS) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Frame FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= 5'd0;
            shift_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
        end
    end

    assign commitWr = (state_q == ST_COMMIT) && shift_q[15];
    assign wrAddr   = shift_q[14:8];
    assign wrData   = shift_q[7:0];

    // Staging is copied to the core only when something is pending and the core is at a period boundary or stopped
    assign transfer = pending_q && (period_end_i || !ctrlEn_q);

    // Register writes and shadow reload; a write landing with a reload keeps pending so it goes out next boundary
    always_comb begin
        ctrlEn_d      = ctrlEn_q;
        ctrlInv_d     = ctrlInv_q;
        dutyStage_d   = dutyStage_q;
        periodStage_d = periodStage_q;
        duty_d        = duty_q;
        period_d      = period_q;
        pending_d     = pending_q;
        update_d      = transfer;

        if (transfer) begin
            duty_d    = dutyStage_q;
            period_d  = periodStage_q;
            pending_d = 1'b0;
        end

        if (commitWr) begin
            case (wrAddr)
                ADDR_CTRL: begin
                    ctrlEn_d  = wrData[0];
                    ctrlInv_d = wrData[1];
                end
                ADDR_DUTY: begin
                    dutyStage_d = wrData;
                    pending_d   = 1'b1;
                end
                ADDR_PERIOD: begin
                    periodStage_d = wrData;
                    pending_d     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Register file, shadow stage and reload pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrlEn_q      <= 1'b0;
            ctrlInv_q     <= 1'b0;
            dutyStage_q   <= 8'h00;
            periodStage_q <= RESET_PERIOD;
            duty_q        <= 8'h00;
            period_q      <= RESET_PERIOD;
            pending_q     <= 1'b0;
            update_q      <= 1'b0;
        end else begin
            ctrlEn_q      <= ctrlEn_d;
            ctrlInv_q     <= ctrlInv_d;
            dutyStage_q   <= dutyStage_d;
            periodStage_q <= periodStage_d;
            duty_q        <= duty_d;
            period_q      <= period_d;
            pending_q     <= pending_d;
            update_q      <= update_d;
        end
    end

    assign pwm_en_o  = ctrlEn_q;
    assign pwm_inv_o = ctrlInv_q;
    assign duty_o    = duty_q;
    assign period_o  = period_q;
    assign update_o  = update_q;

`ifdef PWM_SPI_READBACK_EN
    logic       sclkFall;
    logic [6:0] rdAddr;
    logic [7:0] rdData;
    logic [7:0] tx_q, tx_d;

    assign sclkFall = ~sclkS & sclkDly_q;

    // The address is complete on the 8th rising edge: its last bit is the mosi sample being shifted in now
    assign rdAddr = {shift_q[5:0], mosiS};

    // Readback multiplexer; unmapped addresses read as zero
    always_comb begin
        rdData = 8'h00;
        case (rdAddr)
            ADDR_CTRL:   rdData = {6'b000000, ctrlInv_q, ctrlEn_q};
            ADDR_DUTY:   rdData = dutyStage_q;
            ADDR_PERIOD: rdData = periodStage_q;
            ADDR_STATUS: rdData = {7'b0000000, pending_q};
            default:     rdData = 8'h00;
        endcase
    end

    // Output shifter: load on edge 8 of a read, hold bit7 through edge 9, then advance on falling edges from there
    always_comb begin
        tx_d = tx_q;
        if (csS) begin
            tx_d = 8'h00;
        end else if ((state_q == ST_IDLE) && csFall) begin
            tx_d = 8'h00;
        end else if ((state_q == ST_SHIFT) && sclkRise && (bitCnt_q == 5'd7)) begin
            tx_d = shift_q[6] ? 8'h00 : rdData;
        end else if ((state_q == ST_SHIFT) && sclkFall && (bitCnt_q >= 5'd9)) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    // Output shifter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q <= 8'h00;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign spi.miso_o = tx_q[7];
`else
    assign spi.miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_spi_regs.sv
// Self-checking bench for pwm_spi_regs: table-driven register writes plus
// hand-written sequences for shadowing, aborts, simultaneous events, readback
// and reset mid-frame. Reload pulses are checked against a scoreboard queue.
module tb_pwm_spi_regs;

    typedef struct {
        logic [15:0] frame;
        logic        expUpd;
        logic        expEn;
        logic        expInv;
        logic [7:0]  expDuty;
        logic [7:0]  expPeriod;
    } vec_t;

    typedef struct {
        logic [7:0] duty;
        logic [7:0] period;
    } upd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       periodEnd;
    logic       pwmEn;
    logic       pwmInv;
    logic [7:0] duty;
    logic [7:0] period;
    logic       update;

    int   checkCount = 0;
    int   errorCount = 0;
    int   updCount   = 0;
    logic updPrev    = 1'b0;
    upd_t expQ[$];

    pwm_spi_regs_if spiBus ();

    pwm_spi_regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi          (spiBus),
        .period_end_i (periodEnd),
        .pwm_en_o     (pwmEn),
        .pwm_inv_o    (pwmInv),
        .duty_o       (duty),
        .period_o     (period),
        .update_o     (update)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulsePeriodEnd();
        periodEnd = 1'b1;
        waitClks(1);
        periodEnd = 1'b0;
    endtask

    // Bit-bang an SPI mode-0 frame; optionally raise period_end exactly in the commit cycle
    task automatic applyStimulus(input logic [15:0] word, input int nbits, input logic raiseCs,
                                 input logic simPulse, output logic [15:0] rx);
        rx = 16'h0000;
        spiBus.cs_n_i = 1'b0;
        waitClks(4);
        for (int i = 0; i < nbits; i++) begin
            spiBus.mosi_i = word[15-i];
            waitClks(4);
            rx = {rx[14:0], spiBus.miso_o};
            spiBus.sclk_i = 1'b1;
            if (simPulse && (i == nbits - 1)) begin
                repeat (3) @(posedge clk);
                #1;
                periodEnd = 1'b1;
                waitClks(1);
                periodEnd = 1'b0;
                waitClks(2);
            end else begin
                waitClks(4);
            end
            spiBus.sclk_i = 1'b0;
        end
        waitClks(4);
        if (raiseCs) begin
            spiBus.cs_n_i = 1'b1;
            waitClks(6);
        end
    endtask

    // Scoreboard: every reload pulse must match the oldest queued expectation and last one clock
    always @(negedge clk) begin
        if (rst_n) begin
            if (update) begin
                upd_t e;
                updCount++;
                checkOutput("update_width", int'(updPrev), 0);
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL update_unexpected: got reload duty=0x%0h period=0x%0h, expected none",
                             duty, period);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_duty", int'(duty), int'(e.duty));
                    checkOutput("sb_period", int'(period), int'(e.period));
                end
            end
            updPrev = update;
        end else begin
            updPrev = 1'b0;
        end
    end

    initial begin
        vec_t        vecs[10];
        logic [15:0] rx;
        int          updBefore;

        vecs[0] = '{16'h8140, 1'b1, 1'b0, 1'b0, 8'h40, 8'hFF};
        vecs[1] = '{16'h8210, 1'b1, 1'b0, 1'b0, 8'h40, 8'h10};
        vecs[2] = '{16'h8190, 1'b1, 1'b0, 1'b0, 8'h90, 8'h10};
        vecs[3] = '{16'h8002, 1'b0, 1'b0, 1'b1, 8'h90, 8'h10};
        vecs[4] = '{16'h8577, 1'b0, 1'b0, 1'b1, 8'h90, 8'h10};
        vecs[5] = '{16'h8377, 1'b0, 1'b0, 1'b1, 8'h90, 8'h10};
        vecs[6] = '{16'h0140, 1'b0, 1'b0, 1'b1, 8'h90, 8'h10};
        vecs[7] = '{16'h8000, 1'b0, 1'b0, 1'b0, 8'h90, 8'h10};
        vecs[8] = '{16'h80FE, 1'b0, 1'b0, 1'b1, 8'h90, 8'h10};
        vecs[9] = '{16'h8230, 1'b1, 1'b0, 1'b1, 8'h90, 8'h30};

        spiBus.sclk_i = 1'b0;
        spiBus.cs_n_i = 1'b1;
        spiBus.mosi_i = 1'b0;
        periodEnd     = 1'b0;
        rst_n         = 1'b0;
        waitClks(2);
        checkOutput("reset_en", int'(pwmEn), 0);
        checkOutput("reset_inv", int'(pwmInv), 0);
        checkOutput("reset_duty", int'(duty), 8'h00);
        checkOutput("reset_period", int'(period), 8'hFF);
        checkOutput("reset_update", int'(update), 0);
        checkOutput("reset_miso", int'(spiBus.miso_o), 0);
        rst_n = 1'b1;
        waitClks(4);

        $display("[TB] table-driven writes with the core disabled");
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].expUpd) begin
                expQ.push_back('{vecs[v].expDuty, vecs[v].expPeriod});
            end
            updBefore = updCount;
            applyStimulus(vecs[v].frame, 16, 1'b1, 1'b0, rx);
            checkOutput($sformatf("vec%0d_en", v), int'(pwmEn), int'(vecs[v].expEn));
            checkOutput($sformatf("vec%0d_inv", v), int'(pwmInv), int'(vecs[v].expInv));
            checkOutput($sformatf("vec%0d_duty", v), int'(duty), int'(vecs[v].expDuty));
            checkOutput($sformatf("vec%0d_period", v), int'(period), int'(vecs[v].expPeriod));
            checkOutput($sformatf("vec%0d_updates", v), updCount - updBefore, int'(vecs[v].expUpd));
        end

        $display("[TB] shadowed DUTY write while enabled");
        applyStimulus(16'h8001, 16, 1'b1, 1'b0, rx);
        checkOutput("shadow_en", int'(pwmEn), 1);
        checkOutput("shadow_inv", int'(pwmInv), 0);
        updBefore = updCount;
        applyStimulus(16'h8180, 16, 1'b1, 1'b0, rx);
        waitClks(50);
        checkOutput("shadow_duty_held", int'(duty), 8'h90);
        checkOutput("shadow_no_update", updCount - updBefore, 0);
        expQ.push_back('{8'h80, 8'h30});
        pulsePeriodEnd();
        checkOutput("shadow_duty_loaded", int'(duty), 8'h80);
        checkOutput("shadow_update_hi", int'(update), 1);
        waitClks(1);
        checkOutput("shadow_update_lo", int'(update), 0);

        $display("[TB] aborted frame");
        applyStimulus(16'h8000, 16, 1'b1, 1'b0, rx);
        updBefore = updCount;
        applyStimulus(16'h82FF, 10, 1'b1, 1'b0, rx);
        waitClks(20);
        checkOutput("abort_period", int'(period), 8'h30);
        checkOutput("abort_no_update", updCount - updBefore, 0);
        expQ.push_back('{8'h80, 8'h55});
        applyStimulus(16'h8255, 16, 1'b1, 1'b0, rx);
        checkOutput("after_abort_period", int'(period), 8'h55);

        $display("[TB] commit coinciding with period_end");
        applyStimulus(16'h8001, 16, 1'b1, 1'b0, rx);
        updBefore = updCount;
        applyStimulus(16'h8220, 16, 1'b1, 1'b1, rx);
        waitClks(10);
        checkOutput("simul_period_held", int'(period), 8'h55);
        checkOutput("simul_no_update", updCount - updBefore, 0);
        expQ.push_back('{8'h80, 8'h20});
        pulsePeriodEnd();
        checkOutput("simul_period_loaded", int'(period), 8'h20);

        $display("[TB] readback frames");
        applyStimulus(16'h82A5, 16, 1'b1, 1'b0, rx);
        applyStimulus(16'h0200, 16, 1'b1, 1'b0, rx);
`ifdef PWM_SPI_READBACK_EN
        checkOutput("readback_period", int'(rx[7:0]), 8'hA5);
`else
        checkOutput("readback_period", int'(rx), 0);
`endif
        applyStimulus(16'h0300, 16, 1'b1, 1'b0, rx);
`ifdef PWM_SPI_READBACK_EN
        checkOutput("readback_status", int'(rx[7:0]), 8'h01);
`else
        checkOutput("readback_status", int'(rx), 0);
`endif
        checkOutput("miso_idle", int'(spiBus.miso_o), 0);
        expQ.push_back('{8'h80, 8'hA5});
        pulsePeriodEnd();
        checkOutput("readback_period_loaded", int'(period), 8'hA5);
        waitClks(2);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(16'h8011, 12, 1'b0, 1'b0, rx);
        rst_n = 1'b0;
        waitClks(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spiBus.mosi_i = 1'b1;
            waitClks(4);
            spiBus.sclk_i = 1'b1;
            waitClks(4);
            spiBus.sclk_i = 1'b0;
        end
        spiBus.cs_n_i = 1'b1;
        waitClks(8);
        checkOutput("midreset_en", int'(pwmEn), 0);
        checkOutput("midreset_inv", int'(pwmInv), 0);
        checkOutput("midreset_duty", int'(duty), 8'h00);
        checkOutput("midreset_period", int'(period), 8'hFF);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
